fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Shares one FIFO write port among NumReq producers using round-robin arbitration with bounded bursts.
- Each producer has a valid/ready handshake; the arbiter drives the FIFO's writeEn/writeData and obeys the FIFO full flag.
- Sits between producer blocks and the FIFO write side; purely single-clock.

Parameters:
- NumReq, 4, number of requesters (>=2).
- DataWidth, 32, data word width; must match the FIFO.
- BurstLen, 4, max consecutive beats granted to one requester before re-arbitration (>=1).
- IdWidth, $clog2(NumReq), localparam, width of grant id.

Ports:
- clk  in  1  clock, all state on rising edge.
- rstN  in  1  synchronous active-low reset.
- reqValid  in  NumReq  per-requester data valid.
- reqData  in  NumReq*DataWidth  packed data; requester i occupies bits [i*DataWidth +: DataWidth].
- reqReady  out  NumReq  per-requester ready; a beat transfers when reqValid[i] && reqReady[i].
- fifoWriteEn  out  1  to FIFO writeEn.
- fifoWriteData  out  DataWidth  to FIFO writeData.
- fifoFull  in  1  from FIFO full.
- grantId  out  IdWidth  current owner or candidate index.
- busy  out  1  high when in OWN state or a transfer occurs this cycle.

Behaviour:
- Reset: clk and rstN are as decided (one clock; reset synchronous, active-low).
  - State -> IDLE, beatCnt -> 0, lastOwner -> NumReq-1, so requester 0 has top priority after reset.
  - While rstN is low, reqReady, fifoWriteEn and busy are forced 0 and grantId is 0.
  - Reset mid-burst abandons the burst; no partial state survives.
- States: IDLE and OWN; owner register (IdWidth); beatCnt of width $clog2(BurstLen+1).
- IDLE, combinational winner search:
  - Candidate = first i with reqValid[i], searching (lastOwner+1) mod NumReq upward with wrap.
  - No valid request: grantId = lastOwner, no transfer, stay IDLE.
  - Valid candidate: grantId = candidate and reqReady[candidate] = !fifoFull.
  - Transfer happens this cycle if !fifoFull (zero-latency grant).
  - On transfer: owner <= candidate, lastOwner <= candidate, beatCnt <= 1. Go to OWN if BurstLen > 1, else stay IDLE.
  - fifoFull with a valid candidate: no transfer, stay IDLE, lastOwner unchanged; re-arbitrate next cycle. A newly valid higher-priority requester may win.
- OWN:
  - grantId = owner; reqReady[owner] = !fifoFull; all other readies are 0.
  - reqValid[owner] && !fifoFull: transfer and beatCnt++. If beatCnt+1 == BurstLen, go to IDLE.
  - reqValid[owner] && fifoFull: stall; hold state and beatCnt.
  - !reqValid[owner]: go to IDLE with no transfer this cycle (one bubble).
- Datapath:
  - fifoWriteEn = transfer this cycle, meaning exactly one reqValid&&reqReady pair.
  - fifoWriteData = reqData slice of grantId, valid only when fifoWriteEn.
  - fifoWriteEn is never high while fifoFull is high.
- Invariants:
  - At most one reqReady bit is high.
  - No beat is duplicated or dropped.
  - Per-requester beat order is preserved.
  - A single continuously valid requester sees 100% throughput. The burst-end IDLE cycle re-grants combinationally, with no bubble.
- Fairness: with all requesters continuously valid and FIFO never full, grants rotate 0,1,...,NumReq-1 in blocks of BurstLen beats.

Test Plan:
- Reset: rstN=0 for 3 cycles with reqValid=4'b1111 -> reqReady=0, fifoWriteEn=0. First cycle after release -> grantId=0, reqReady=4'b0001, write of req0 data.
- Fairness: req0 and req1 always valid, BurstLen=4, fifoFull=0 -> grantId sequence 0,0,0,0,1,1,1,1,0,... and fifoWriteEn high every cycle.
- Full stall: fifoFull=1 for 3 cycles after req2's 2nd beat -> fifoWriteEn=0 and reqReady=0 for 3 cycles. Then req2 completes exactly 2 more beats before re-arbitration.
- Owner drops: req1 drops valid after 2 beats, req3 valid -> one cycle with fifoWriteEn=0, then grantId=3 and writes resume.
- Single requester: only req3 valid for 12 cycles, data 0..11 -> 12 consecutive writes, data 0..11 in order, no bubbles.
- Reset mid-burst: rstN=0 during req1's 3rd beat, all valid -> no write during reset. After release, grantId=0 (lastOwner reset), beatCnt restarts at 1.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Shares a single FIFO write port among NumReq producers. Arbitration is
// round-robin; after it wins, a requester keeps the port for up to BurstLen
// consecutive beats. Grants are zero-latency: in IDLE the winner is found
// combinationally, and its first beat transfers in the same cycle.
//
// Parameters
//   NumReq    : number of requesters (>= 2)
//   DataWidth : data word width (matches the FIFO)
//   BurstLen  : max consecutive beats per grant (>= 1)
//   IdWidth   : width of grantId (derived)
//
// Ports
//   clk           : clock; all state changes on the rising edge
//   rstN          : synchronous active-low reset
//   reqValid      : per-requester data valid
//   reqData       : packed data; requester i at [i*DataWidth +: DataWidth]
//   reqReady      : per-requester ready (at most one bit high)
//   fifoWriteEn   : FIFO write enable (one beat transferred this cycle)
//   fifoWriteData : FIFO write data (slice of the granted requester)
//   fifoFull      : FIFO full flag
//   grantId       : current owner, or IDLE candidate / last owner
//   busy          : high in OWN or when a transfer happens this cycle
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter  int NumReq    = 4,
    parameter  int DataWidth = 32,
    parameter  int BurstLen  = 4,
    localparam int IdWidth   = $clog2(NumReq)
) (
    input  logic                        clk,
    input  logic                        rstN,
    input  logic [NumReq-1:0]           reqValid,
    input  logic [NumReq*DataWidth-1:0] reqData,
    output logic [NumReq-1:0]           reqReady,
    output logic                        fifoWriteEn,
    output logic [DataWidth-1:0]        fifoWriteData,
    input  logic                        fifoFull,
    output logic [IdWidth-1:0]          grantId,
    output logic                        busy
);

    localparam int CntWidth = $clog2(BurstLen + 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t                state_q,     state_d;
    logic [IdWidth-1:0]    owner_q,     owner_d;
    logic [IdWidth-1:0]    lastOwner_q, lastOwner_d;
    logic [CntWidth-1:0]   beatCnt_q,   beatCnt_d;

    logic                  candFound;
    logic [IdWidth-1:0]    candIdx;
    logic [IdWidth-1:0]    grantSel;
    logic                  xfer;
    logic [CntWidth-1:0]   cntInc;

    // Round-robin search starting just after the last owner. When the last
    // owner is the only valid requester the search wraps back to it, which
    // gives back-to-back bursts with no bubble.
    always_comb begin
        int                 idx;
        logic [IdWidth-1:0] idxv;
        candFound = 1'b0;
        candIdx   = lastOwner_q;
        idx       = 0;
        idxv      = '0;
        for (int k = 1; k <= NumReq; k++) begin
            idx = int'(lastOwner_q) + k;
            if (idx >= NumReq) begin
                idx = idx - NumReq;
            end
            idxv = IdWidth'(idx);
            if (!candFound && reqValid[idxv]) begin
                candFound = 1'b1;
                candIdx   = idxv;
            end
        end
    end

    // Handshake outputs. Reset forces every output to its idle value even
    // though the registers only clear on the next edge.
    always_comb begin
        reqReady = '0;
        grantSel = '0;
        xfer     = 1'b0;
        busy     = 1'b0;
        if (rstN) begin
            if (state_q == OWN) begin
                grantSel          = owner_q;
                reqReady[owner_q] = !fifoFull;
                xfer              = reqValid[owner_q] && !fifoFull;
                busy              = 1'b1;
            end else begin
                grantSel = candFound ? candIdx : lastOwner_q;
                if (candFound) begin
                    reqReady[candIdx] = !fifoFull;
                    xfer              = !fifoFull;
                end
                busy = xfer;
            end
        end
    end

    assign grantId     = grantSel;
    assign fifoWriteEn = xfer;

    // Data mux; the value only matters when fifoWriteEn is high.
    always_comb begin
        fifoWriteData = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (grantSel == IdWidth'(i)) begin
                fifoWriteData = reqData[i*DataWidth +: DataWidth];
            end
        end
    end

    assign cntInc = beatCnt_q + CntWidth'(1);

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastOwner_d = lastOwner_q;
        beatCnt_d   = beatCnt_q;
        if (state_q == IDLE) begin
            if (xfer) begin
                owner_d     = candIdx;
                lastOwner_d = candIdx;
                beatCnt_d   = CntWidth'(1);
                state_d     = (BurstLen > 1) ? OWN : IDLE;
            end
        end else begin
            if (!reqValid[owner_q]) begin
                // Owner went quiet: give up the rest of the burst.
                state_d   = IDLE;
                beatCnt_d = '0;
            end else if (!fifoFull) begin
                beatCnt_d = cntInc;
                if (cntInc == CntWidth'(BurstLen)) begin
                    state_d = IDLE;
                end
            end
        end
    end

    // State registers; lastOwner resets to NumReq-1 so requester 0 is
    // searched first after reset.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            lastOwner_q <= IdWidth'(NumReq - 1);
            beatCnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastOwner_q <= lastOwner_d;
            beatCnt_q   <= beatCnt_d;
        end
    end

endmodule
